debug_wr_entry: RTL
===================

// Module: debug_wr_entry
// PURPOSE
//  Write-side counterpart of the core's debug read port (debug_addr -> debug_data).
//  Assembles a 32-bit word from hex nibbles entered on switches with debounced button pulses.
//  On commit, issues a req/ack write to the core's debug write port (register file or memory).
//  Sits in the board top, between btn_scan/SW and RV32core. The live entry value feeds the 7-seg display.
// PARAMETERS
//  DATA_W     32    write data width; must be a multiple of 4
//  ADDR_W     7     debug address width, equal to the core's debug_addr width
//  TIMEOUT    1024  clk cycles wr_req may stay high without wr_ack before aborting (>=2)
// PORTS
//  clk         in   1       system clock; single clock domain, same as the core's clk
//  rstn        in   1       asynchronous, active-low reset
//  nibble_in   in   4       hex digit from switches
//  addr_in     in   ADDR_W  target debug address from switches
//  btn_shift   in   1       1-cycle pulse: shift nibble_in into the entry word
//  btn_commit  in   1       1-cycle pulse: start the write
//  btn_clear   in   1       1-cycle pulse: clear the entry word and the error flag
//  wr_ack      in   1       core accepted the write; level, may last >1 cycle
//  wr_req      out  1       write request, held until acknowledged
//  wr_addr     out  ADDR_W  address, stable while wr_req=1
//  wr_data     out  DATA_W  data, stable while wr_req=1
//  entry_data  out  DATA_W  current entry word, for display
//  nib_cnt     out  4       number of nibbles entered, saturates at DATA_W/4
//  busy        out  1       FSM is in REQ
//  done        out  1       1-cycle pulse: write completed
//  err         out  1       sticky flag: timeout occurred
// BEHAVIOUR
//  Reset (async, rstn=0): all outputs 0, FSM=IDLE, timeout counter=0. wr_req drops immediately, even mid-request.
//  FSM states: IDLE, REQ, DONE.
//  IDLE
//   - Priority when pulses coincide: clear > commit > shift. Only the highest-priority pulse acts.
//   - clear: entry_data=0, nib_cnt=0, err=0.
//   - shift: entry_data <= {entry_data[DATA_W-5:0], nibble_in}. nib_cnt+1, saturating.
//     Shifting past full keeps shifting; the oldest nibble is dropped.
//   - commit with nib_cnt==0: ignored; no request, no err.
//   - commit with nib_cnt>0: latch wr_addr=addr_in and wr_data=entry_data.
//     wr_req=1 from the next cycle. Clear the counter. Go to REQ.
//  REQ (busy=1)
//   - All button pulses are ignored, including clear.
//   - wr_ack sampled 1: wr_req=0 next cycle, go to DONE.
//     entry_data and nib_cnt are cleared on this same transition.
//   - Counter reaches TIMEOUT-1 with no ack: wr_req=0, err=1, go to IDLE. entry_data is kept for retry.
//   - Ack and the timeout in the same cycle: ack wins; no err.
//  DONE: done=1 for exactly one cycle, then IDLE. wr_ack is ignored outside REQ.
//  Latency: commit pulse at cycle N -> wr_req high at N+1.
//   Ack sampled at cycle M -> wr_req low and done high at M+1.
//  wr_addr and wr_data hold their last values after the request; they are meaningful only while wr_req=1.
//  The core must not assert wr_ack without wr_req. A stale ack that is still high in the next REQ is accepted.
// STRUCTURE
//  Shared package debug_pkg:
//   - typedef for the state enum {IDLE, REQ, DONE}
//   - DBG_ADDR_W=7, DBG_DATA_W=32, NIBBLES=DBG_DATA_W/4
//  One sub-module: nibble_shift_reg.
//   - Inputs: clear, shift, nibble.
//   - Outputs: word and saturating count.
//  FSM and timeout counter (width $clog2(TIMEOUT)) live in the top-level block.
// TESTING
//  1. Shift 1,2,3,4,5,6,7,8, commit with addr_in=7'h05, core acks 3 cycles later.
//     -> wr_req for 4 cycles with wr_data=32'h12345678, wr_addr=5; then done pulse, entry_data=0.
//  2. Shift 9 nibbles (1..9). -> entry_data=32'h23456789, nib_cnt=8.
//  3. Commit with nib_cnt=0. -> wr_req stays 0, busy stays 0, err stays 0.
//  4. Commit, never ack.
//     -> wr_req deasserts after TIMEOUT cycles, err=1, entry_data kept.
//     -> Clear then gives err=0 and entry_data=0.
//  5. Clear, commit and shift in one cycle -> clear only.
//     Shift and commit in REQ -> ignored, wr_data unchanged.
//  6. Pulse rstn low mid-REQ (asynchronously, between clock edges).
//     -> wr_req=0 before the next edge; after release, IDLE with all outputs 0.

Source files
------------

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and sizes for the debug write-entry block
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DBG_ADDR_W = 7;
    localparam int DBG_DATA_W = 32;
    localparam int NIBBLES    = DBG_DATA_W / 4;

endpackage

// File: rtl/nibble_shift_reg.sv
// rtl/nibble_shift_reg.sv - hex-nibble entry word with saturating nibble count
module nibble_shift_reg
    import debug_pkg::*;
#(
    parameter int DATA_W = DBG_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              shift,
    input  logic [3:0]        nibble,
    output logic [DATA_W-1:0] word,
    output logic [3:0]        count
);

    localparam logic [3:0] CNT_FULL = 4'(DATA_W / 4);

    logic [DATA_W-1:0] word_q, word_d;
    logic [3:0]        count_q, count_d;

    // Clear wins over shift; once full, shifting keeps dropping the oldest nibble.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (clear) begin
            word_d  = '0;
            count_d = 4'd0;
        end else if (shift) begin
            word_d  = {word_q[DATA_W-5:0], nibble};
            count_d = (count_q == CNT_FULL) ? count_q : count_q + 4'd1;
        end
    end

    // Entry word and count registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q  <= '0;
            count_q <= 4'd0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign word  = word_q;
    assign count = count_q;

endmodule

// File: rtl/debug_wr_entry.sv
// rtl/debug_wr_entry.sv - builds a word from switch nibbles and writes it to the core debug port
module debug_wr_entry
    import debug_pkg::*;
#(
    parameter int DATA_W  = DBG_DATA_W,
    parameter int ADDR_W  = DBG_ADDR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [3:0]        nibble_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              btn_shift,
    input  logic              btn_commit,
    input  logic              btn_clear,
    input  logic              wr_ack,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] entry_data,
    output logic [3:0]        nib_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              sr_clear;
    logic              sr_shift;

    nibble_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (sr_clear),
        .shift  (sr_shift),
        .nibble (nibble_in),
        .word   (entry_data),
        .count  (nib_cnt)
    );

    // Next-state logic: buttons act only in IDLE (clear > commit > shift); REQ waits for ack or timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        sr_clear  = 1'b0;
        sr_shift  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_clear) begin
                    sr_clear = 1'b1;
                    err_d    = 1'b0;
                end else if (btn_commit) begin
                    if (nib_cnt != 4'd0) begin
                        wr_addr_d = addr_in;
                        wr_data_d = entry_data;
                        wr_req_d  = 1'b1;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        state_d   = REQ;
                    end
                end else if (btn_shift) begin
                    sr_shift = 1'b1;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    sr_clear = 1'b1;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    wr_req_d = 1'b0;
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_req  = wr_req_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
